cep_loop_ctrl: RTL and testbench
================================

Name: cep_loop_ctrl

Overview:
- Sequencer for the cepstral (DCT) stage of the MFCC pipeline.
- On a start pulse it walks a two-level loop: coefficient index outer, mel-filterbank index inner.
- Drives DCT ROM address and MAC clear/enable strobes, and flags each finished cepstral coefficient to the output packer.
- Sits between the log-mel buffer and the cepstral MAC; replaces the per-loop free-running counters with one controller having a start/busy/done handshake.

Parameters:
- CEP_WIDTH, 7: width of coefficient index and cfg_num_cep.
- MEL_WIDTH, 6: width of mel index and cfg_num_mel.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to process one frame; honoured only in IDLE.
- cfg_num_cep  in  CEP_WIDTH  last coefficient index, inclusive; captured when start is accepted.
- cfg_num_mel  in  MEL_WIDTH  last mel index, inclusive; captured when start is accepted.
- hold  in  1  downstream stall; freezes loop progress while high.
- mel_idx  out  MEL_WIDTH  current mel index (buffer read address).
- cep_idx  out  CEP_WIDTH  current coefficient index.
- dct_addr  out  CEP_WIDTH+MEL_WIDTH  {cep_idx, mel_idx}, DCT ROM address.
- mac_en  out  1  a MAC term is issued this cycle.
- mac_clr  out  1  first term of a coefficient; accumulator loads instead of adding.
- coef_valid  out  1  one-cycle pulse: accumulator holds a finished coefficient.
- coef_idx  out  CEP_WIDTH  index of the coefficient flagged by coef_valid.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Registered state; all outputs except dct_addr are registered. dct_addr is a concatenation of registered indices.
- Reset (rst_n low at an edge): state=IDLE, all outputs 0, captured config 0. A reset mid-frame aborts with no coef_valid and no done.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 → capture C=cfg_num_cep and M=cfg_num_mel; cep_idx=0, mel_idx=0; go to RUN.
  - start is accepted regardless of hold.
- RUN, each cycle with hold=0:
  - mac_en=1; mac_clr=(mel_idx==0).
  - If mel_idx<M: mel_idx+1.
  - Else: mel_idx=0 and cep_idx+1. If cep_idx==C as well: go to FLUSH, indices hold last values.
- RUN, hold=1: mac_en=0, mac_clr=0, indices frozen, no state change.
- coef_valid: registered one cycle after any cycle with mac_en=1 and mel_idx==M. coef_idx is the cep_idx of that term. It is not gated by hold.
- FLUSH: exactly one cycle; mac_en=0; hold ignored; carries the final coef_valid; then go to DONE.
- DONE: done=1 for one cycle, indices cleared to 0, then go to IDLE.
- start while busy or in DONE is ignored; it is not queued.
- Latency with no hold: start sampled at edge 0 → terms issued in cycles 1..(C+1)(M+1) → FLUSH in the next cycle → done one cycle later. Total: start to done = (C+1)(M+1)+2 cycles.
- Arithmetic: indices never exceed captured limits; no modular wrap beyond M/C.
- Boundaries:
  - M=0: every term has both mac_clr=1 and coef_valid follows each term.
  - C=0: a single coefficient.
  - Config input changes during a frame have no effect.

Optional Feature:
CEP_SKIP_C0_EN:
- Defined: coefficient 0 (energy term) is skipped. cep_idx starts at 1 on start. Terms issued = C·(M+1). If C=0, the FSM goes IDLE→DONE directly: no mac_en, no coef_valid, done two cycles after start.
- Undefined: behaviour exactly as above, starting at cep_idx=0.

Test Plan:
- C=2, M=3, hold=0, pulse start → 12 mac_en cycles; mac_clr in cycles 1,5,9; coef_valid with coef_idx 0,1,2 in cycles 5,9,13; done in cycle 14; busy high cycles 1–13.
- C=1, M=2; hold=1 in cycles 3–5 → indices frozen at mel=2,cep=0; mac_en=0 during hold; done delayed 3 cycles, arriving in cycle 11.
- C=0, M=0 → one term with mac_clr=1, mac_en=1 in cycle 1; coef_valid in cycle 2 with coef_idx=0; done in cycle 3.
- Start re-pulsed at cycle 4 of a C=3,M=3 run, and cfg changed to C=0 → ignored; the frame still produces 4 coefficients; done in cycle 18.
- rst_n low at cycle 6 of a C=2,M=3 run → next edge: state IDLE, all outputs 0, no done; a fresh start then runs the full 12 terms.
- With CEP_SKIP_C0_EN: C=2, M=1 → 4 terms, coef_idx 1,2; with C=0 → done in cycle 2, mac_en never asserted.

Source files
------------

// File: rtl/cep_loop_ctrl_if.sv
// cep_loop_ctrl_if: bundles the frame request/config/stall inputs and the
//   loop-index, MAC-strobe and status outputs of the cepstral loop controller.
// Ports: master = requester side (drives start/cfg/hold); slave = controller.
interface cep_loop_ctrl_if #(
  parameter int CEP_WIDTH = 7,
  parameter int MEL_WIDTH = 6
);
  logic                           start;
  logic [CEP_WIDTH-1:0]           cfg_num_cep;
  logic [MEL_WIDTH-1:0]           cfg_num_mel;
  logic                           hold;
  logic [MEL_WIDTH-1:0]           mel_idx;
  logic [CEP_WIDTH-1:0]           cep_idx;
  logic [CEP_WIDTH+MEL_WIDTH-1:0] dct_addr;
  logic                           mac_en;
  logic                           mac_clr;
  logic                           coef_valid;
  logic [CEP_WIDTH-1:0]           coef_idx;
  logic                           busy;
  logic                           done;

  modport master (
    output start, cfg_num_cep, cfg_num_mel, hold,
    input  mel_idx, cep_idx, dct_addr, mac_en, mac_clr,
           coef_valid, coef_idx, busy, done
  );

  modport slave (
    input  start, cfg_num_cep, cfg_num_mel, hold,
    output mel_idx, cep_idx, dct_addr, mac_en, mac_clr,
           coef_valid, coef_idx, busy, done
  );
endinterface

// File: rtl/cep_loop_ctrl.sv
// cep_loop_ctrl: DCT-stage sequencer, coefficient loop outer, mel loop inner.
// Latency: first MAC term the cycle after start; done (C+1)(M+1)+2 cycles after start.
// Backpressure: hold freezes indices and blanks mac_en; FLUSH/DONE ignore hold.
// Ports: i_clk, i_rst_n (synchronous, active-low), io_ctl (slave modport:
//   start/cfg/hold in; mel/cep indices, dct_addr, mac_en/mac_clr,
//   coef_valid/coef_idx, busy, done out).
// Option: define CEP_SKIP_C0_EN to skip coefficient 0 (energy term).
module cep_loop_ctrl #(
  parameter int CEP_WIDTH = 7,
  parameter int MEL_WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  cep_loop_ctrl_if.slave   io_ctl
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  localparam logic [CEP_WIDTH-1:0] CEP_ONE = CEP_WIDTH'(1);
  localparam logic [MEL_WIDTH-1:0] MEL_ONE = MEL_WIDTH'(1);

  state_t               r_state,    w_state;
  logic [CEP_WIDTH-1:0] r_num_cep,  w_num_cep;
  logic [MEL_WIDTH-1:0] r_num_mel,  w_num_mel;
  logic [CEP_WIDTH-1:0] r_cep,      w_cep;
  logic [MEL_WIDTH-1:0] r_mel,      w_mel;
  logic                 r_mac_en,   w_mac_en;
  logic                 r_mac_clr,  w_mac_clr;
  logic                 r_coef_vld, w_coef_vld;
  logic [CEP_WIDTH-1:0] r_coef_idx, w_coef_idx;
  logic                 r_busy,     w_busy;
  logic                 r_done,     w_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_num_cep  <= '0;
      r_num_mel  <= '0;
      r_cep      <= '0;
      r_mel      <= '0;
      r_mac_en   <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_coef_vld <= 1'b0;
      r_coef_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_num_cep  <= w_num_cep;
      r_num_mel  <= w_num_mel;
      r_cep      <= w_cep;
      r_mel      <= w_mel;
      r_mac_en   <= w_mac_en;
      r_mac_clr  <= w_mac_clr;
      r_coef_vld <= w_coef_vld;
      r_coef_idx <= w_coef_idx;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Registered outputs describe the current cycle, so every next-value below
  // is what the following cycle must show. A term shown with mac_en=1 has been
  // issued; the indices advance on the first non-held edge after it.
  always_comb begin
    w_state    = r_state;
    w_num_cep  = r_num_cep;
    w_num_mel  = r_num_mel;
    w_cep      = r_cep;
    w_mel      = r_mel;
    w_mac_en   = 1'b0;
    w_mac_clr  = 1'b0;
    w_done     = 1'b0;
    // The term just issued closes a coefficient when it was the last mel bin;
    // this is independent of hold, the MAC result is already complete.
    w_coef_vld = r_mac_en && (r_mel == r_num_mel);
    w_coef_idx = w_coef_vld ? r_cep : r_coef_idx;

    case (r_state)
      ST_IDLE: begin
        if (io_ctl.start) begin
          w_num_cep = io_ctl.cfg_num_cep;
          w_num_mel = io_ctl.cfg_num_mel;
          w_mel     = '0;
`ifdef CEP_SKIP_C0_EN
          if (io_ctl.cfg_num_cep == '0) begin
            // Nothing to compute: DONE is entered with done low and raises it
            // one cycle later.
            w_cep   = '0;
            w_state = ST_DONE;
          end else begin
            w_cep     = CEP_ONE;
            w_mac_en  = 1'b1;
            w_mac_clr = 1'b1;
            w_state   = ST_RUN;
          end
`else
          w_cep     = '0;
          w_mac_en  = 1'b1;
          w_mac_clr = 1'b1;
          w_state   = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (!io_ctl.hold) begin
          if (r_mel < r_num_mel) begin
            w_mel    = r_mel + MEL_ONE;
            w_mac_en = 1'b1;
          end else if (r_cep < r_num_cep) begin
            w_mel     = '0;
            w_cep     = r_cep + CEP_ONE;
            w_mac_en  = 1'b1;
            w_mac_clr = 1'b1;
          end else begin
            // Last term issued; indices keep their final values in FLUSH.
            w_state = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        w_cep   = '0;
        w_mel   = '0;
        w_done  = 1'b1;
        w_state = ST_DONE;
      end
      ST_DONE: begin
        // Normally done is already high here; only the skipped-frame path
        // arrives with done low and needs a second DONE cycle.
        if (r_done) begin
          w_state = ST_IDLE;
        end else begin
          w_done = 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy = (w_state == ST_RUN) || (w_state == ST_FLUSH);
  end

  assign io_ctl.mel_idx    = r_mel;
  assign io_ctl.cep_idx    = r_cep;
  assign io_ctl.dct_addr   = {r_cep, r_mel};
  assign io_ctl.mac_en     = r_mac_en;
  assign io_ctl.mac_clr    = r_mac_clr;
  assign io_ctl.coef_valid = r_coef_vld;
  assign io_ctl.coef_idx   = r_coef_idx;
  assign io_ctl.busy       = r_busy;
  assign io_ctl.done       = r_done;

endmodule

// File: tb/tb_cep_loop_ctrl.sv
// tb_cep_loop_ctrl: scoreboard bench for cep_loop_ctrl. The driver builds a
// timeline of expected MAC terms, coefficients and done for each frame from
// the loop limits and the hold pattern; a negedge monitor consumes them.
module tb_cep_loop_ctrl;
  localparam int CW = 7;
  localparam int MW = 6;
`ifdef CEP_SKIP_C0_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cep_loop_ctrl_if #(.CEP_WIDTH(CW), .MEL_WIDTH(MW)) bus ();
  cep_loop_ctrl #(.CEP_WIDTH(CW), .MEL_WIDTH(MW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_ctl (bus)
  );

  typedef struct {int cyc; int cep; int mel; bit clr;} term_t;
  typedef struct {int cyc; int idx;} coef_t;

  term_t term_q[$];
  coef_t coef_q[$];
  int    done_q[$];
  bit    hold_arr[];

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int s_edge = 0;
  int flush_cyc = 0;
  bit mon_on = 1'b0;
  bit frame_active = 1'b0;

  always @(posedge clk) edge_cnt++;

  function automatic bit get_hold(int e);
    if (e >= 0 && e < hold_arr.size()) return hold_arr[e];
    return 1'b0;
  endfunction

  task automatic clear_holds();
    hold_arr = new[64];
    foreach (hold_arr[i]) hold_arr[i] = 1'b0;
  endtask

  task automatic make_holds(input int n, input int pct);
    hold_arr = new[4 * n + 40];
    foreach (hold_arr[i]) hold_arr[i] = ($urandom_range(99) < pct);
  endtask

  // Timeline model: term k+1 appears the cycle after the first non-held edge
  // following term k; a coefficient is flagged the cycle after its last bin.
  task automatic build_model(input int c, input int m, output int done_cyc);
    int t;
    int e;
    int c0;
    bit first;
    c0 = SKIP ? 1 : 0;
    first = 1'b1;
    t = 0;
    if (SKIP && c == 0) begin
      flush_cyc = 0;
      done_cyc  = 2;
    end else begin
      for (int cp = c0; cp <= c; cp++) begin
        for (int ml = 0; ml <= m; ml++) begin
          if (first) begin
            t = 1;
            first = 1'b0;
          end else begin
            e = t;
            while (get_hold(e)) e++;
            t = e + 1;
          end
          term_q.push_back('{t, cp, ml, (ml == 0)});
          if (ml == m) coef_q.push_back('{t + 1, cp});
        end
      end
      e = t;
      while (get_hold(e)) e++;
      flush_cyc = e + 1;
      done_cyc  = e + 2;
    end
    done_q.push_back(done_cyc);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({bus.mel_idx, bus.cep_idx, bus.dct_addr, bus.mac_en, bus.mac_clr,
         bus.coef_valid, bus.coef_idx, bus.busy, bus.done} !== '0) begin
      miscompares++;
      $display("FAIL %s: mel=%0d cep=%0d addr=%0d en=%b clr=%b cv=%b ci=%0d busy=%b done=%b, all required 0",
               name, bus.mel_idx, bus.cep_idx, bus.dct_addr, bus.mac_en, bus.mac_clr,
               bus.coef_valid, bus.coef_idx, bus.busy, bus.done);
    end
  endtask

  task automatic check_empty(input string name);
    vectors++;
    if (term_q.size() != 0 || coef_q.size() != 0 || done_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: missing events terms=%0d coefs=%0d dones=%0d, required 0/0/0",
               name, term_q.size(), coef_q.size(), done_q.size());
    end
  endtask

  // rep_at: edge index of an ignored re-pulse of start (0 = none), carrying cfg rep_c.
  // abort_at: edge index at which rst_n is pulled low (0 = none).
  task automatic run_frame(input string name, input int c, input int m,
                           input int rep_at, input int rep_c, input int abort_at);
    int done_cyc;
    @(negedge clk);
    build_model(c, m, done_cyc);
    s_edge = edge_cnt + 1;
    frame_active = 1'b1;
    bus.start = 1'b1;
    bus.cfg_num_cep = CW'(c);
    bus.cfg_num_mel = MW'(m);
    bus.hold = 1'($urandom_range(1));
    for (int r = 1; r <= done_cyc; r++) begin
      @(negedge clk);
      if (r == abort_at) begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        term_q.delete();
        coef_q.delete();
        done_q.delete();
        frame_active = 1'b0;
        @(negedge clk);
        check_idle({name, "_abort"});
        rst_n = 1'b1;
        return;
      end
      bus.start = (r == rep_at);
      bus.cfg_num_cep = (r == rep_at) ? CW'(rep_c) : CW'($urandom);
      bus.cfg_num_mel = MW'($urandom);
      bus.hold = get_hold(r);
    end
    bus.start = 1'b0;
    bus.hold = 1'b0;
    @(negedge clk);
    frame_active = 1'b0;
    check_empty(name);
  endtask

  always @(negedge clk) begin
    int rc;
    int exp_addr;
    int exp_busy;
    term_t tx;
    coef_t cx;
    int dx;
    if (mon_on) begin
      rc = edge_cnt - s_edge + 1;
      vectors++;
      if (bus.mac_en === 1'b1) begin
        if (term_q.size() == 0) begin
          miscompares++;
          $display("FAIL term: unexpected mac_en at cycle %0d cep=%0d mel=%0d, required none",
                   rc, bus.cep_idx, bus.mel_idx);
        end else begin
          tx = term_q.pop_front();
          exp_addr = tx.cep * (1 << MW) + tx.mel;
          if (rc != tx.cyc || int'(bus.cep_idx) != tx.cep || int'(bus.mel_idx) != tx.mel ||
              bus.mac_clr !== tx.clr || int'(bus.dct_addr) != exp_addr) begin
            miscompares++;
            $display("FAIL term: got cyc=%0d cep=%0d mel=%0d clr=%b addr=%0d, required cyc=%0d cep=%0d mel=%0d clr=%b addr=%0d",
                     rc, bus.cep_idx, bus.mel_idx, bus.mac_clr, bus.dct_addr,
                     tx.cyc, tx.cep, tx.mel, tx.clr, exp_addr);
          end
        end
      end else if (bus.mac_clr !== 1'b0) begin
        miscompares++;
        $display("FAIL mac_clr: got %b without mac_en at cycle %0d, required 0", bus.mac_clr, rc);
      end
      if (bus.coef_valid === 1'b1) begin
        vectors++;
        if (coef_q.size() == 0) begin
          miscompares++;
          $display("FAIL coef: unexpected coef_valid at cycle %0d idx=%0d, required none", rc, bus.coef_idx);
        end else begin
          cx = coef_q.pop_front();
          if (rc != cx.cyc || int'(bus.coef_idx) != cx.idx) begin
            miscompares++;
            $display("FAIL coef: got cyc=%0d idx=%0d, required cyc=%0d idx=%0d",
                     rc, bus.coef_idx, cx.cyc, cx.idx);
          end
        end
      end
      if (bus.done === 1'b1) begin
        vectors++;
        if (done_q.size() == 0) begin
          miscompares++;
          $display("FAIL done: unexpected done at cycle %0d, required none", rc);
        end else begin
          dx = done_q.pop_front();
          if (rc != dx) begin
            miscompares++;
            $display("FAIL done: got cycle %0d, required cycle %0d", rc, dx);
          end
        end
      end
      if (frame_active) begin
        vectors++;
        exp_busy = (rc >= 1 && rc <= flush_cyc) ? 1 : 0;
        if (int'(bus.busy) != exp_busy) begin
          miscompares++;
          $display("FAIL busy: got %b at cycle %0d, required %0d", bus.busy, rc, exp_busy);
        end
      end
    end
  end

  initial begin
    int c;
    int m;
    int rep;
    int ab;
    bus.start = 1'b0;
    bus.cfg_num_cep = '0;
    bus.cfg_num_mel = '0;
    bus.hold = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    mon_on = 1'b1;

    clear_holds();
    run_frame("c2m3", 2, 3, 0, 0, 0);
    clear_holds();
    hold_arr[3] = 1'b1;
    hold_arr[4] = 1'b1;
    hold_arr[5] = 1'b1;
    run_frame("c1m2_hold", 1, 2, 0, 0, 0);
    clear_holds();
    run_frame("c0m0", 0, 0, 0, 0, 0);
    run_frame("restart_ignored", 3, 3, 4, 0, 0);
    run_frame("abort_c2m3", 2, 3, 0, 0, 6);
    run_frame("after_abort", 2, 3, 0, 0, 0);
    run_frame("c2m1", 2, 1, 0, 0, 0);
    run_frame("c0m3", 0, 3, 0, 0, 0);
    run_frame("c5m0", 5, 0, 0, 0, 0);
    run_frame("max", (1 << CW) - 1, (1 << MW) - 1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 5);
      m = $urandom_range(0, 6);
      make_holds((c + 1) * (m + 1), 25);
      rep = ($urandom_range(1) != 0) ? $urandom_range(1, (c + 1) * (m + 1) + 2) : 0;
      ab  = ($urandom_range(7) == 0) ? $urandom_range(1, (c + 1) * (m + 1)) : 0;
      run_frame("random", c, m, rep, $urandom_range(0, 7), ab);
    end

    repeat (2) @(negedge clk);
    check_empty("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
